// File: rtl/line_cache.sv
// Single-line pixel buffer: simple-dual-port RAM with a registered read port.
// Written by the SDRAM fetch side, read one column ahead by the VGA scan side.
module line_cache #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    // Index width covers exactly DEPTH entries; range checks use the full address.
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic             wr_in_range;
    logic             rd_in_range;
    logic             wr_fire;
    logic             rd_clear;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    always_comb begin
        wr_in_range = ({1'b0, wr_addr} < DEPTH_LIM);
        rd_in_range = ({1'b0, rd_addr} < DEPTH_LIM);
        wr_fire     = wr_en && !reset && wr_in_range;
        // Out-of-range reads share the output register's synchronous clear.
        rd_clear    = reset || !rd_in_range;
        wr_idx      = wr_addr[IDX_W-1:0];
        rd_idx      = rd_addr[IDX_W-1:0];
    end

    // Array has no reset so it maps onto block RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // Read-first: a same-address write on this edge is not yet visible here.
    always_ff @(posedge clk) begin
        if (rd_clear) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_idx];
        end
    end

endmodule

// File: tb/tb_line_cache.sv
// Directed bench for line_cache (DEPTH=640): vector table plus reset, streaming
// and out-of-range sequences.
module tb_line_cache;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 640;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    int errors;
    int checks;

    line_cache #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_en  (wr_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
        logic [ADDR_W-1:0] ra;
        logic              chk;
        logic [DATA_W-1:0] exp;
    } vec_t;

    vec_t tbl [9];

    task automatic drive(input logic we, input logic [ADDR_W-1:0] wa,
                         input logic [DATA_W-1:0] wd, input logic [ADDR_W-1:0] ra,
                         input logic rst);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_addr = ra;
        reset   = rst;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [DATA_W-1:0] exp);
        checks++;
        if (rd_data !== exp) begin
            errors++;
            $display("FAIL %s: rd_data=%02h expected=%02h", name, rd_data, exp);
        end
    endtask

    initial begin
        logic [ADDR_W-1:0] xa;
        logic [DATA_W-1:0] xd;
        logic [DATA_W-1:0] nd;
        errors = 0;
        checks = 0;

        // Basic write/read and read-during-write vectors.
        tbl[0] = '{we: 1'b1, wa: 10'd5,   wd: 8'hA5, ra: 10'd5,   chk: 1'b0, exp: 8'h00};
        tbl[1] = '{we: 1'b0, wa: 10'd5,   wd: 8'hFF, ra: 10'd5,   chk: 1'b1, exp: 8'hA5};
        tbl[2] = '{we: 1'b0, wa: 10'd5,   wd: 8'hFF, ra: 10'd5,   chk: 1'b1, exp: 8'hA5};
        tbl[3] = '{we: 1'b1, wa: 10'd7,   wd: 8'h11, ra: 10'd5,   chk: 1'b1, exp: 8'hA5};
        tbl[4] = '{we: 1'b1, wa: 10'd7,   wd: 8'h22, ra: 10'd7,   chk: 1'b1, exp: 8'h11};
        tbl[5] = '{we: 1'b0, wa: 10'd0,   wd: 8'h00, ra: 10'd7,   chk: 1'b1, exp: 8'h22};
        tbl[6] = '{we: 1'b1, wa: 10'd700, wd: 8'h77, ra: 10'd700, chk: 1'b1, exp: 8'h00};
        tbl[7] = '{we: 1'b0, wa: 10'd0,   wd: 8'h00, ra: 10'd5,   chk: 1'b1, exp: 8'hA5};
        tbl[8] = '{we: 1'b0, wa: 10'd0,   wd: 8'h00, ra: 10'd1023, chk: 1'b1, exp: 8'h00};

        drive(1'b0, '0, '0, '0, 1'b1);
        drive(1'b0, '0, '0, '0, 1'b1);
        check("reset_init", 8'h00);

        // Reset with a pending write: output clears, write is dropped.
        drive(1'b1, 10'd3, 8'h00, 10'd0, 1'b0);
        drive(1'b1, 10'd4, 8'h3C, 10'd0, 1'b0);
        drive(1'b0, 10'd0, 8'h00, 10'd4, 1'b0);
        check("pre_reset_read4", 8'h3C);
        drive(1'b1, 10'd3, 8'h55, 10'd4, 1'b1);
        check("reset_cycle1", 8'h00);
        drive(1'b1, 10'd3, 8'h55, 10'd4, 1'b1);
        check("reset_cycle2", 8'h00);
        drive(1'b0, 10'd0, 8'h00, 10'd3, 1'b0);
        check("reset_write_ignored", 8'h00);
        drive(1'b0, 10'd0, 8'h00, 10'd4, 1'b0);
        check("read_resumes", 8'h3C);

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].ra, 1'b0);
            if (tbl[i].chk) check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Streaming: first pass fills columns 0..639 with (x+1)[7:0].
        for (int x = 1; x <= 640; x++) begin
            xa = 10'(x);
            xd = 8'(x);
            drive(1'b1, xa - 10'd1, xd, xa, 1'b0);
        end
        for (int x = 0; x < 640; x++) begin
            xa = 10'(x);
            xd = 8'(x);
            nd = 8'(x + 1);
            drive(1'b1, xa - 10'd1, xd, xa, 1'b0);
            check($sformatf("stream_k%0d", x), nd);
        end

        // One-cycle reset mid-stream at column 300.
        for (int x = 290; x <= 310; x++) begin
            xa = 10'(x);
            xd = 8'(x);
            nd = 8'(x + 1);
            drive(1'b1, xa - 10'd1, xd, xa, x == 300);
            if (x == 300) check("midreset_zero", 8'h00);
            else check($sformatf("midreset_k%0d", x), nd);
        end
        drive(1'b0, 10'd0, 8'h00, 10'd100, 1'b0);
        check("midreset_addr100", 8'h65);

        // Out of range writes must not alias onto in-range entries.
        drive(1'b1, 10'd700, 8'h77, 10'd700, 1'b0);
        check("oor_read700", 8'h00);
        drive(1'b1, 10'h3FF, 8'h99, 10'h3FF, 1'b0);
        check("oor_read3ff", 8'h00);
        drive(1'b0, 10'd0, 8'h00, 10'd60, 1'b0);
        check("oor_alias60", 8'h3D);
        drive(1'b0, 10'd0, 8'h00, 10'd188, 1'b0);
        check("oor_alias188", 8'hBD);
        drive(1'b0, 10'd0, 8'h00, 10'd383, 1'b0);
        check("oor_alias383", 8'h80);
        drive(1'b0, 10'd0, 8'h00, 10'd511, 1'b0);
        check("oor_alias511", 8'h00);
        drive(1'b0, 10'd0, 8'h00, 10'd639, 1'b0);
        check("last_entry639", 8'h80);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/line_cache.md
# line_cache

Single-line pixel buffer for the VGA output path: one write port and one read port on a common clock. The SDRAM fetch logic writes 8-bit grayscale pixels at one column address. The VGA scan logic reads the pixel for the current column one cycle later. Each entry stores one pixel; the block is sized for one 640-pixel line with headroom up to 1024.

## Interface
Parameters:
- DATA_W, 8, pixel width in bits
- ADDR_W, 10, address width
- DEPTH, 1024, number of entries; must satisfy 1 <= DEPTH <= 2^ADDR_W

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset  input  1  reset, synchronous, active-high
- wr_addr  input  ADDR_W  write column address (system drives x-1)
- wr_data  input  DATA_W  pixel to store
- wr_en  input  1  active-high write strobe
- rd_addr  input  ADDR_W  read column address (system drives x)
- rd_data  output  DATA_W  registered read data

## Operation
- Storage: DEPTH x DATA_W array. All entries are 0 at power-up/configuration.
- Write: on a rising edge with wr_en=1, reset=0 and wr_addr < DEPTH, store wr_data at mem[wr_addr].
- Write ignore cases: a write with wr_addr >= DEPTH is dropped with no side effect. Writes are also ignored in any cycle with reset=1.
- Read: on every rising edge with reset=0:
  - rd_addr < DEPTH: rd_data <= mem[rd_addr], the contents before this edge's write.
  - rd_addr >= DEPTH: rd_data <= 0.
- Read-during-write, same address on the same edge: rd_data returns the old contents. The new value is visible on the next read.
- Reset:
  - rd_data <= 0 on the reset edge and holds 0 while reset stays high.
  - Memory contents are retained across reset and are not cleared.
- No handshake. The block accepts one write and one read per cycle, unconditionally.
- Address arithmetic is unsigned ADDR_W bits. A wr_addr of 0x3FF (x-1 with x=0) is a normal address when DEPTH=1024 and out of range when DEPTH<1024.
- The array must map to a single simple-dual-port block RAM. The output register is the RAM output register.

## Timing
- Write latency: data written at edge N is readable by a read sampled at edge N+1, appearing on rd_data after N+1.
- Read latency: 1 cycle. rd_data after edge N reflects rd_addr sampled at edge N.
- Throughput: 1 write + 1 read per clk cycle, sustained, with no bubbles.
- rd_data changes only on rising clk edges. There is no combinational path from any input to rd_data.
- Reset takes effect on the first rising edge with reset=1. Reads resume on the first edge with reset=0.

## Test plan
- Reset: hold reset=1 for 2 cycles with wr_en=1, wr_addr=3, wr_data=0x55. Required: rd_data=0x00 throughout; after release, reading address 3 returns 0x00 (write ignored).
- Basic write/read:
  - Write 0xA5 to address 5, then set rd_addr=5. Required: rd_data=0xA5 one edge after the read is sampled.
  - With wr_en=0 and wr_data=0xFF at address 5, a later read still returns 0xA5.
- Collision: with mem[7]=0x11, write 0x22 to address 7 and read address 7 on the same edge. Required: rd_data=0x11, and the next edge's read of 7 returns 0x22.
- Streaming: sweep x from 1 to 640 with wr_addr=x-1, wr_data=x[7:0], rd_addr=x, then sweep a second pass. Required: on the second pass, rd_data one cycle after rd_addr=k equals (k+1)[7:0] for all k in 0..639.
- Reset mid-stream: assert reset for 1 cycle at column 300. Required: rd_data=0 for that cycle; afterwards previously written entries, e.g. address 100 = 101, are intact.
- Out of range (DEPTH=640): write 0x77 to address 700 and read address 700. Required: rd_data=0x00, and no in-range entry is modified.
